// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage with req/ack data-memory FSM and MEM/WB pipeline register.
// Aligned word accesses stall the pipeline until ack or timeout; misaligned ones are dropped.
module mem_wb_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_RegWrite,
    input  logic        i_MemtoReg,
    input  logic        i_MemWrite,
    input  logic        i_MemRead,
    input  logic [31:0] i_ALUresult,
    input  logic [31:0] i_writedata,
    input  logic [4:0]  i_writeReg,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_RegWriteOut,
    output logic        o_MemtoRegOut,
    output logic [31:0] o_readdataOut,
    output logic [31:0] o_ALUresultOut,
    output logic [4:0]  o_writeRegOut,
    output logic        o_misalign,
    output logic        o_buserr
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we, r_rw, r_mtr, r_mis, r_berr;
    logic [31:0]      r_addr, r_wdata, r_rd, r_alu;
    logic [4:0]       r_wreg;
    logic             w_access, w_aligned, w_start, w_tout;
    assign w_access  = i_MemRead | i_MemWrite;
    assign w_aligned = i_ALUresult[1:0] == 2'b00;
    assign w_start   = (r_state == IDLE) && w_access && w_aligned;
    assign w_tout    = r_cnt == CNT_W'(TIMEOUT - 1);
    // The timeout cycle drops stall so the abandoned op retires as a squash.
    assign o_stall        = w_start || ((r_state == WAIT) && !i_dmem_ack && !w_tout);
    assign o_dmem_req     = r_state == WAIT;
    assign o_dmem_we      = r_we;
    assign o_dmem_addr    = r_addr;
    assign o_dmem_wdata   = r_wdata;
    assign o_RegWriteOut  = r_rw;
    assign o_MemtoRegOut  = r_mtr;
    assign o_readdataOut  = r_rd;
    assign o_ALUresultOut = r_alu;
    assign o_writeRegOut  = r_wreg;
    assign o_misalign     = r_mis;
    assign o_buserr       = r_berr;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rw    <= 1'b0;
            r_mtr   <= 1'b0;
            r_rd    <= '0;
            r_alu   <= '0;
            r_wreg  <= '0;
            r_mis   <= 1'b0;
            r_berr  <= 1'b0;
        end else begin
            // Bubble by default; the branches below override when an op retires.
            r_mis  <= 1'b0;
            r_berr <= 1'b0;
            r_rw   <= 1'b0;
            r_mtr  <= 1'b0;
            r_rd   <= '0;
            r_alu  <= '0;
            r_wreg <= '0;
            if (r_state == IDLE) begin
                if (w_start) begin
                    r_state <= WAIT;
                    r_cnt   <= '0;
                    r_we    <= i_MemWrite;
                    r_addr  <= i_ALUresult;
                    r_wdata <= i_writedata;
                end else begin
                    r_rw   <= i_RegWrite & ~w_access;
                    r_mtr  <= i_MemtoReg & ~w_access;
                    r_alu  <= i_ALUresult;
                    r_wreg <= i_writeReg;
                    r_mis  <= w_access;
                end
            end else if (i_dmem_ack) begin
                r_state <= IDLE;
                r_rw    <= i_RegWrite;
                r_mtr   <= i_MemtoReg;
                r_rd    <= r_we ? 32'h0 : i_dmem_rdata;
                r_alu   <= i_ALUresult;
                r_wreg  <= i_writeReg;
            end else if (w_tout) begin
                r_state <= IDLE;
                r_berr  <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed table plus random ops checked against a per-op behavioural model.
module tb_mem_wb_stage;
    localparam int TIMEOUT = 16;
    logic        clk = 1'b0, rst = 1'b1;
    logic        rw, mtr, mw, mr, ack;
    logic [31:0] alu, wd, rdata;
    logic [4:0]  wreg;
    logic        req, we, stall, rw_o, mtr_o, mis, berr;
    logic [31:0] addr, wdata, rd_o, alu_o;
    logic [4:0]  wreg_o;
    int          nchk = 0, nerr = 0;

    typedef struct {
        logic        rw, mtr, mw, mr;
        logic [31:0] alu, wd;
        logic [4:0]  wreg;
        int          lat;
        logic [31:0] rdata;
        int          e_stall, e_req;
        logic        e_rw, e_mtr;
        logic [31:0] e_rd;
        logic        e_mis, e_berr;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    mem_wb_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_RegWrite(rw), .i_MemtoReg(mtr), .i_MemWrite(mw), .i_MemRead(mr),
        .i_ALUresult(alu), .i_writedata(wd), .i_writeReg(wreg),
        .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(addr), .o_dmem_wdata(wdata),
        .i_dmem_ack(ack), .i_dmem_rdata(rdata), .o_stall(stall),
        .o_RegWriteOut(rw_o), .o_MemtoRegOut(mtr_o), .o_readdataOut(rd_o),
        .o_ALUresultOut(alu_o), .o_writeRegOut(wreg_o),
        .o_misalign(mis), .o_buserr(berr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected per-op outcome from the access rules, with no notion of FSM state.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.e_stall = 0; r.e_req = 0; r.e_rw = 0; r.e_mtr = 0; r.e_rd = 0; r.e_mis = 0; r.e_berr = 0;
        if (!(v.mr || v.mw)) begin
            r.e_rw = v.rw; r.e_mtr = v.mtr;
        end else if (v.alu[1:0] != 2'b00) begin
            r.e_mis = 1;
        end else if (v.lat >= 1 && v.lat <= TIMEOUT) begin
            r.e_stall = v.lat; r.e_req = v.lat; r.e_rw = v.rw; r.e_mtr = v.mtr;
            r.e_rd = v.mw ? 32'h0 : v.rdata;
        end else begin
            r.e_stall = TIMEOUT; r.e_req = TIMEOUT; r.e_berr = 1;
        end
        return r;
    endfunction

    task automatic run_op(input vec_t v);
        int ns = 0, nr = 0, bus_bad = 0, bub_bad = 0, cyc = 0;
        logic s;
        rw = v.rw; mtr = v.mtr; mw = v.mw; mr = v.mr; alu = v.alu; wd = v.wd; wreg = v.wreg;
        forever begin
            @(negedge clk);
            if (req) begin
                nr++;
                if (we !== v.mw || addr !== v.alu || wdata !== v.wd) bus_bad++;
                if (rw_o !== 1'b0) bub_bad++;
                ack = (nr == v.lat);
                rdata = ack ? v.rdata : $urandom;
            end else begin
                ack = 1'($urandom_range(0, 1));
                rdata = $urandom;
            end
            #1 s = stall;
            if (s) ns++;
            @(posedge clk);
            #1;
            cyc++;
            if (!s) break;
            if (cyc > 40) begin
                chk("op_hang", 32'(cyc), 32'd40);
                break;
            end
        end
        ack = 0;
        chk("stall_cycles", 32'(ns), 32'(v.e_stall));
        chk("req_cycles", 32'(nr), 32'(v.e_req));
        if (nr > 0) chk("bus_stable", 32'(bus_bad), 0);
        if (nr > 0) chk("wait_bubble", 32'(bub_bad), 0);
        chk("RegWriteOut", 32'(rw_o), 32'(v.e_rw));
        chk("MemtoRegOut", 32'(mtr_o), 32'(v.e_mtr));
        chk("readdataOut", rd_o, v.e_rd);
        chk("ALUresultOut", alu_o, v.e_berr ? 32'h0 : v.alu);
        chk("writeRegOut", 32'(wreg_o), v.e_berr ? 32'h0 : 32'(v.wreg));
        chk("misalign", 32'(mis), 32'(v.e_mis));
        chk("buserr", 32'(berr), 32'(v.e_berr));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, 32'(req), 0);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_wb"}, {25'(0), rw_o, mtr_o, mis, berr, we, 2'b0}, 0);
        chk({tag, "_data"}, rd_o | alu_o | 32'(wreg_o), 0);
    endtask

    initial begin
        vec_t v;
        rw = 0; mtr = 0; mw = 0; mr = 0; alu = 0; wd = 0; wreg = 0; ack = 0; rdata = 0;
        //           rw mtr mw mr alu            wd            wreg lat rdata         stl req rw mtr rd            mis berr
        tbl[0] = '{1, 0, 0, 0, 32'h1234,     32'h0,        5,  0, 32'h0,         0,  0,  1, 0, 32'h0,         0, 0};
        tbl[1] = '{1, 1, 0, 1, 32'h40,       32'h0,        7,  1, 32'hDEADBEEF,  1,  1,  1, 1, 32'hDEADBEEF,  0, 0};
        tbl[2] = '{0, 0, 1, 0, 32'h80,       32'hA5A5A5A5, 0,  3, 32'h11111111,  3,  3,  0, 0, 32'h0,         0, 0};
        tbl[3] = '{1, 1, 0, 1, 32'h42,       32'h0,        9,  1, 32'h0,         0,  0,  0, 0, 32'h0,         1, 0};
        tbl[4] = '{1, 1, 0, 1, 32'h44,       32'h0,        3,  0, 32'h0,         16, 16, 0, 0, 32'h0,         0, 1};
        tbl[5] = '{1, 1, 0, 1, 32'h48,       32'h0,        4, 16, 32'h0BADF00D,  16, 16, 1, 1, 32'h0BADF00D,  0, 0};
        tbl[6] = '{1, 0, 1, 1, 32'h100,      32'h5A5A0000, 2,  2, 32'h22222222,  2,  2,  1, 0, 32'h0,         0, 0};
        tbl[7] = '{0, 0, 1, 0, 32'h81,       32'h12345678, 0,  1, 32'h0,         0,  0,  0, 0, 32'h0,         1, 0};
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        rst = 0;
        for (int i = 0; i < 8; i++) run_op(tbl[i]);
        // Reset during the second WAIT cycle discards the access without a bus error.
        mr = 1; mw = 0; rw = 1; mtr = 1; alu = 32'h200; wreg = 3; ack = 0;
        repeat (2) @(posedge clk);
        #1 chk("rst_mid_req_before", 32'(req), 1);
        rst = 1; mr = 0; rw = 0; mtr = 0; alu = 0; wreg = 0;
        @(posedge clk);
        #1 chk_zero("rst_wait");
        rst = 0;
        run_op(tbl[0]);
        for (int i = 0; i < 150; i++) begin
            v.rw = 1'($urandom); v.mtr = 1'($urandom);
            v.mw = ($urandom_range(0, 3) == 0); v.mr = ($urandom_range(0, 2) == 0);
            v.alu = $urandom;
            if ($urandom_range(0, 3) != 0) v.alu[1:0] = 2'b00;
            v.wd = $urandom; v.wreg = 5'($urandom); v.lat = $urandom_range(0, 20);
            v.rdata = $urandom;
            run_op(model(v));
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
